pa_clint_mp_regs: RTL and testbench

PA_CLINT_MP_REGS -- requirements
Module: pa_clint_mp_regs

---
 rtl/pa_clint_pkg.sv | 51 +++++
 rtl/pa_clint_hart_timer.sv | 46 ++++
 rtl/pa_clint_mp_regs.sv | 112 +++++++++++
 tb/tb_pa_clint_mp_regs.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pa_clint_pkg.sv
// CLINT address map constants and the shared bus-address decoder.
package pa_clint_pkg;

    localparam logic [15:0] MSIP_BASE       = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE   = 16'h4000;
    localparam logic [15:0] MTIME_LO_ADDR   = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_ADDR   = 16'hBFFC;
    localparam int unsigned MSIP_STRIDE     = 4;
    localparam int unsigned MTIMECMP_STRIDE = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } clint_reg_e;

    typedef struct packed {
        clint_reg_e kind;
        logic [2:0] hart;
    } clint_dec_t;

    // Offsets are taken unsigned so an address below a base wraps high and misses.
    function automatic clint_dec_t clint_decode(input logic [15:0] addr,
                                                input int unsigned hart_num);
        clint_dec_t  dec;
        logic [15:0] word;
        logic [31:0] msip_off;
        logic [31:0] cmp_off;
        word     = addr & 16'hFFFC;
        msip_off = {16'd0, word} - {16'd0, MSIP_BASE};
        cmp_off  = {16'd0, word} - {16'd0, MTIMECMP_BASE};
        dec.kind = REG_NONE;
        dec.hart = '0;
        if (word == MTIME_LO_ADDR) begin
            dec.kind = REG_MTIME_LO;
        end else if (word == MTIME_HI_ADDR) begin
            dec.kind = REG_MTIME_HI;
        end else if (msip_off < MSIP_STRIDE * hart_num) begin
            dec.kind = REG_MSIP;
            dec.hart = 3'(msip_off / MSIP_STRIDE);
        end else if (cmp_off < MTIMECMP_STRIDE * hart_num) begin
            dec.kind = cmp_off[2] ? REG_CMP_HI : REG_CMP_LO;
            dec.hart = 3'(cmp_off / MTIMECMP_STRIDE);
        end
        return dec;
    endfunction

endpackage

// File: rtl/pa_clint_hart_timer.sv
// Per-hart CLINT state: msip, mtimecmp and the registered timer compare.
module pa_clint_hart_timer #(
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        msip_we_i,
    input  logic        cmp_lo_we_i,
    input  logic        cmp_hi_we_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] mtime_i,
    output logic        msip_o,
    output logic [63:0] mtimecmp_o,
    output logic        mtip_o
);

    logic        msip_q, msip_d;
    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q, mtip_d;

    always_comb begin
        msip_d = msip_q;
        cmp_d  = cmp_q;
        if (msip_we_i)   msip_d        = wdata_i[0];
        if (cmp_lo_we_i) cmp_d[31:0]   = wdata_i;
        if (cmp_hi_we_i) cmp_d[63:32]  = wdata_i;
        mtip_d = (mtime_i >= cmp_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            msip_q <= 1'b0;
            cmp_q  <= MTIMECMP_RST;
            mtip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
            cmp_q  <= cmp_d;
            mtip_q <= mtip_d;
        end
    end

    assign msip_o     = msip_q;
    assign mtimecmp_o = cmp_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/pa_clint_mp_regs.sv
// Multi-hart CLINT register block: mtime counter, bus decode and registered response.
module pa_clint_mp_regs
    import pa_clint_pkg::*;
#(
    parameter int unsigned HART_NUM     = 4,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                clint_clk,
    input  logic                cpurst_b,
    input  logic                tcipif_clint_sel,
    input  logic                tcipif_clint_write,
    input  logic [15:0]         tcipif_clint_addr,
    input  logic [31:0]         tcipif_clint_wdata,
    input  logic                clint_time_tick,
    output logic                clint_tcipif_cmplt,
    output logic [31:0]         clint_tcipif_rdata,
    output logic                clint_tcipif_err,
    output logic [HART_NUM-1:0] clint_hart_msip,
    output logic [HART_NUM-1:0] clint_hart_mtip,
    output logic [63:0]         clint_mtime
);

    clint_dec_t          dec;
    logic                acc_wr, acc_rd;
    logic [63:0]         mtime_q, mtime_d;
    logic                cmplt_q;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [HART_NUM-1:0] msip_we, cmp_lo_we, cmp_hi_we;
    logic [HART_NUM-1:0] hart_msip, hart_mtip;
    logic [63:0]         hart_cmp [HART_NUM];

    assign dec    = clint_decode(tcipif_clint_addr, HART_NUM);
    assign acc_wr = tcipif_clint_sel & tcipif_clint_write;
    assign acc_rd = tcipif_clint_sel & ~tcipif_clint_write;

    always_comb begin
        msip_we   = '0;
        cmp_lo_we = '0;
        cmp_hi_we = '0;
        rdata_d   = '0;
        for (int unsigned h = 0; h < HART_NUM; h++) begin
            if (dec.hart == 3'(h)) begin
                msip_we[h]   = acc_wr && (dec.kind == REG_MSIP);
                cmp_lo_we[h] = acc_wr && (dec.kind == REG_CMP_LO);
                cmp_hi_we[h] = acc_wr && (dec.kind == REG_CMP_HI);
                if (acc_rd) begin
                    case (dec.kind)
                        REG_MSIP:   rdata_d = {31'd0, hart_msip[h]};
                        REG_CMP_LO: rdata_d = hart_cmp[h][31:0];
                        REG_CMP_HI: rdata_d = hart_cmp[h][63:32];
                        default:    ;
                    endcase
                end
            end
        end
        if (acc_rd && dec.kind == REG_MTIME_LO) rdata_d = mtime_q[31:0];
        if (acc_rd && dec.kind == REG_MTIME_HI) rdata_d = mtime_q[63:32];
        err_d = tcipif_clint_sel && (dec.kind == REG_NONE);
    end

    // A bus write to either half suppresses that cycle's tick entirely.
    always_comb begin
        mtime_d = mtime_q;
        if (acc_wr && dec.kind == REG_MTIME_LO) begin
            mtime_d[31:0] = tcipif_clint_wdata;
        end else if (acc_wr && dec.kind == REG_MTIME_HI) begin
            mtime_d[63:32] = tcipif_clint_wdata;
        end else if (clint_time_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clint_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            mtime_q <= '0;
            cmplt_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            mtime_q <= mtime_d;
            cmplt_q <= tcipif_clint_sel;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < HART_NUM; g++) begin : g_hart
        pa_clint_hart_timer #(
            .MTIMECMP_RST (MTIMECMP_RST)
        ) u_timer (
            .clk_i       (clint_clk),
            .rst_n_i     (cpurst_b),
            .msip_we_i   (msip_we[g]),
            .cmp_lo_we_i (cmp_lo_we[g]),
            .cmp_hi_we_i (cmp_hi_we[g]),
            .wdata_i     (tcipif_clint_wdata),
            .mtime_i     (mtime_q),
            .msip_o      (hart_msip[g]),
            .mtimecmp_o  (hart_cmp[g]),
            .mtip_o      (hart_mtip[g])
        );
    end

    assign clint_tcipif_cmplt = cmplt_q;
    assign clint_tcipif_rdata = rdata_q;
    assign clint_tcipif_err   = err_q;
    assign clint_hart_msip    = hart_msip;
    assign clint_hart_mtip    = hart_mtip;
    assign clint_mtime        = mtime_q;

endmodule

// File: tb/tb_pa_clint_mp_regs.sv
// Scoreboard bench for pa_clint_mp_regs against a behavioural CLINT model.
module tb_pa_clint_mp_regs;

    localparam int unsigned H = 4;
    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0, wr = 1'b0, tick = 1'b0;
    logic [15:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic          cmplt, err;
    logic [31:0]   rdata;
    logic [H-1:0]  msip, mtip;
    logic [63:0]   mtime;

    pa_clint_mp_regs #(.HART_NUM(H), .MTIMECMP_RST(CMP_RST)) dut (
        .clint_clk          (clk),
        .cpurst_b           (rst_n),
        .tcipif_clint_sel   (sel),
        .tcipif_clint_write (wr),
        .tcipif_clint_addr  (addr),
        .tcipif_clint_wdata (wdata),
        .clint_time_tick    (tick),
        .clint_tcipif_cmplt (cmplt),
        .clint_tcipif_rdata (rdata),
        .clint_tcipif_err   (err),
        .clint_hart_msip    (msip),
        .clint_hart_mtip    (mtip),
        .clint_mtime        (mtime)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
    resp_t q[$];

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp [H];
    logic [H-1:0] m_msip, m_mtip;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 none, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
    task automatic m_decode(input logic [15:0] a_in, output int kind, output int hart);
        int unsigned a;
        a = int'(a_in) & 32'hFFFC;
        kind = 0;
        hart = 0;
        if (a < 4 * H) begin
            kind = 1; hart = int'(a / 4);
        end else if (a >= 32'h4000 && a < 32'h4000 + 8 * H) begin
            hart = int'((a - 32'h4000) / 8);
            kind = ((a - 32'h4000) % 8 == 4) ? 3 : 2;
        end else if (a == 32'hBFF8) begin
            kind = 4;
        end else if (a == 32'hBFFC) begin
            kind = 5;
        end
    endtask

    task automatic m_reset();
        m_mtime = '0;
        m_msip  = '0;
        m_mtip  = '0;
        for (int h = 0; h < H; h++) m_cmp[h] = CMP_RST;
    endtask

    task automatic step(input bit s, input bit w, input logic [15:0] a,
                        input logic [31:0] d, input bit t);
        int kind, hart;
        resp_t r;
        sel = s; wr = w; addr = a; wdata = d; tick = t;
        m_decode(a, kind, hart);
        if (s) begin
            r.err   = (kind == 0);
            r.rdata = '0;
            if (!w) begin
                case (kind)
                    1: r.rdata = {31'd0, m_msip[hart]};
                    2: r.rdata = m_cmp[hart][31:0];
                    3: r.rdata = m_cmp[hart][63:32];
                    4: r.rdata = m_mtime[31:0];
                    5: r.rdata = m_mtime[63:32];
                    default: ;
                endcase
            end
            q.push_back(r);
        end
        @(posedge clk);
        for (int h = 0; h < H; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
        if (s && w && kind == 4)      m_mtime[31:0]  = d;
        else if (s && w && kind == 5) m_mtime[63:32] = d;
        else if (t)                   m_mtime        = m_mtime + 64'd1;
        if (s && w && kind == 1) m_msip[hart] = d[0];
        if (s && w && kind == 2) m_cmp[hart][31:0]  = d;
        if (s && w && kind == 3) m_cmp[hart][63:32] = d;
        @(negedge clk);
        sel = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        sel = 1'b0; tick = 1'b0;
        rst_n = 1'b0;
        q.delete();
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each completion.
    always @(posedge clk) begin
        resp_t r;
        #1;
        if (!rst_n) begin
            chk("rst_cmplt", {63'd0, cmplt}, 64'd0);
            chk("rst_err",   {63'd0, err},   64'd0);
            chk("rst_rdata", {32'd0, rdata}, 64'd0);
            chk("rst_mtime", mtime, 64'd0);
            chk("rst_msip",  {60'd0, msip},  64'd0);
            chk("rst_mtip",  {60'd0, mtip},  64'd0);
        end else begin
            chk("mtime", mtime, m_mtime);
            chk("msip",  {60'd0, msip}, {60'd0, m_msip});
            chk("mtip",  {60'd0, mtip}, {60'd0, m_mtip});
            if (cmplt) begin
                if (q.size() == 0) begin
                    chk("unexpected_cmplt", {63'd0, cmplt}, 64'd0);
                end else begin
                    r = q.pop_front();
                    chk("rdata", {32'd0, rdata}, {32'd0, r.rdata});
                    chk("err",   {63'd0, err},   {63'd0, r.err});
                end
            end else begin
                if (q.size() != 0) begin
                    r = q.pop_front();
                    chk("missing_cmplt", {63'd0, cmplt}, 64'd1);
                end
                chk("idle_rdata", {32'd0, rdata}, 64'd0);
                chk("idle_err",   {63'd0, err},   64'd0);
            end
        end
    end

    function automatic logic [15:0] pick_addr();
        logic [15:0] a;
        case ($urandom_range(0, 5))
            0:       a = 16'(4 * $urandom_range(0, 7));
            1, 2:    a = 16'(16'h4000 + 4 * $urandom_range(0, 15));
            3:       a = ($urandom_range(0, 1) != 0) ? 16'hBFF8 : 16'hBFFC;
            default: a = 16'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        m_reset();
        do_reset();

        // Timer compare on hart 1 at mtime 16
        step(1, 1, 16'h4008, 32'h10, 0);
        step(1, 1, 16'h400C, 32'h0, 0);
        repeat (20) step(0, 0, '0, '0, 1);
        chk("req033_mtip", {60'd0, mtip}, 64'h2);

        // Carry from lo into hi
        step(1, 1, 16'hBFF8, 32'hFFFF_FFFF, 0);
        step(1, 1, 16'hBFFC, 32'h0, 0);
        step(0, 0, '0, '0, 1);
        chk("req034_carry", mtime, 64'h1_0000_0000);

        // Write beats a same-cycle tick
        do_reset();
        step(1, 1, 16'hBFF8, 32'h5, 1);
        chk("req035_prio", mtime, 64'd5);

        // Back-to-back mapped then out-of-range hart read
        step(1, 0, 16'h000C, '0, 0);
        step(1, 0, 16'h0010, '0, 0);

        // msip takes only bit 0
        step(1, 1, 16'h0000, 32'hFFFF_FFFF, 0);
        step(1, 0, 16'h0000, '0, 0);
        step(0, 0, '0, '0, 0);
        chk("req038_msip0", {63'd0, msip[0]}, 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            a = pick_addr();
            d = $urandom;
            if (a[15:12] == 4'h4 && $urandom_range(0, 1) != 0)
                d = a[2] ? m_mtime[63:32] : m_mtime[31:0] + 32'($urandom_range(0, 12));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, a, d,
                 $urandom_range(0, 1) != 0);
        end

        // Reset lands in the cycle after sel; the access must never complete
        step(1, 1, 16'h4000, 32'h1234, 1);
        step(1, 1, 16'h0008, 32'h1, 1);
        sel = 1'b1; wr = 1'b0; addr = 16'hBFF8;
        @(posedge clk);
        rst_n = 1'b0;
        sel = 1'b0;
        q.delete();
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int h = 0; h < H; h++) begin
            step(1, 0, 16'(16'h4000 + 8 * h), '0, 0);
            step(1, 0, 16'(16'h4004 + 8 * h), '0, 0);
            step(1, 0, 16'(4 * h), '0, 0);
        end

        step(0, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
